// File: rtl/stack_ctrl_if.sv
// Bundle between the LIFO controller, its upstream requester and the StackMem RAM.
// The upstream side and the RAM model share the master modport; the controller takes the slave modport.
interface stack_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) ();
    logic                  clear;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_ready;
    logic                  pop_req;
    logic                  pop_ready;
    logic                  pop_valid;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output clear, push_valid, push_data, pop_req, mem_rdata,
        input  push_ready, pop_ready, pop_valid, pop_data, count, full, empty,
               overflow, underflow, mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport slave (
        input  clear, push_valid, push_data, pop_req, mem_rdata,
        output push_ready, pop_ready, pop_valid, pop_data, count, full, empty,
               overflow, underflow, mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO controller in front of a 1-cycle registered-read RAM: owns the stack pointer,
// turns push/pop requests into RAM accesses and reports occupancy and sticky error flags.
module stack_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    stack_ctrl_if.slave  bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_V   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] sp;
    logic [ADDR_WIDTH:0] sp_m1;
    logic                full_w;
    logic                empty_w;
    logic                push_ready_w;
    logic                pop_ready_w;
    logic                push_fire;
    logic                pop_fire;
    logic                pop_valid_r;
    logic                overflow_r;
    logic                underflow_r;

    assign sp_m1        = sp - ONE_V;
    assign full_w       = (sp == DEPTH_V);
    assign empty_w      = (sp == '0);
    assign pop_ready_w  = !empty_w;
    // A simultaneous pop frees the top slot, so a full stack can still take a push.
    assign push_ready_w = !full_w || (bus.pop_req && !empty_w);
    assign push_fire    = bus.push_valid && push_ready_w;
    assign pop_fire     = bus.pop_req && pop_ready_w;

    assign bus.push_ready = push_ready_w;
    assign bus.pop_ready  = pop_ready_w;
    assign bus.count      = sp;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.overflow   = overflow_r;
    assign bus.underflow  = underflow_r;
    assign bus.pop_valid  = pop_valid_r;
    assign bus.pop_data   = bus.mem_rdata;

    // Read address always tracks the top so it is already on the RAM output when popped;
    // on push+pop the RAM reads before writing, so the old top returns and is replaced.
    assign bus.mem_raddr = sp_m1[ADDR_WIDTH-1:0];
    assign bus.mem_waddr = pop_fire ? sp_m1[ADDR_WIDTH-1:0] : sp[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = bus.push_data;
    assign bus.mem_we    = push_fire && !bus.clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp          <= '0;
            pop_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.clear) begin
            sp          <= '0;
            pop_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_fire && !pop_fire) begin
                sp <= sp + ONE_V;
            end else if (pop_fire && !push_fire) begin
                sp <= sp_m1;
            end
            pop_valid_r <= pop_fire;
            if (bus.push_valid && !push_ready_w) begin
                overflow_r <= 1'b1;
            end
            if (bus.pop_req && !pop_ready_w) begin
                underflow_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural RAM, reference stack model and a pop-result scoreboard.
module tb_stack_ctrl;
    logic clock;
    logic reset_n;

    stack_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) sif ();

    stack_ctrl #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // StackMem stand-in: registered read that returns the pre-write contents.
    logic [11:0] ram [256];
    always @(posedge clock) begin
        if (sif.mem_we) ram[sif.mem_waddr] <= sif.mem_wdata;
        sif.mem_rdata <= ram[sif.mem_raddr];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          msp     = 0;
    logic [11:0] sm [256];
    bit          movf    = 0;
    bit          munf    = 0;
    bit          mpv     = 0;
    bit          mon_en  = 0;
    logic [11:0] exp_q [$];
    logic [11:0] exp_d;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        msp  = 0;
        movf = 0;
        munf = 0;
        mpv  = 0;
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, sif.count, msp);
        check({tag, "_full"}, sif.full, msp == 256);
        check({tag, "_empty"}, sif.empty, msp == 0);
        check({tag, "_overflow"}, sif.overflow, movf);
        check({tag, "_underflow"}, sif.underflow, munf);
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model, check state.
    task automatic cyc(input bit pv, input logic [11:0] pd, input bit pr, input bit clr);
        bit pop_ok;
        bit push_ok;
        bit pv_next;
        sif.push_valid = pv;
        sif.push_data  = pd;
        sif.pop_req    = pr;
        sif.clear      = clr;
        #1;
        pop_ok  = pr && (msp > 0);
        push_ok = pv && ((msp < 256) || pop_ok);
        pv_next = 0;
        check("push_ready", sif.push_ready, (msp < 256) || (pr && msp > 0));
        check("pop_ready", sif.pop_ready, msp > 0);
        check("mem_we", sif.mem_we, push_ok && !clr);
        check("mem_raddr", sif.mem_raddr, (msp - 1) & 255);
        if (push_ok && !clr) begin
            check("mem_waddr", sif.mem_waddr, pop_ok ? ((msp - 1) & 255) : (msp & 255));
            check("mem_wdata", sif.mem_wdata, pd);
        end
        if (clr) begin
            msp  = 0;
            movf = 0;
            munf = 0;
        end else begin
            if (pv && !push_ok) movf = 1;
            if (pr && !pop_ok) munf = 1;
            if (pop_ok && push_ok) begin
                exp_q.push_back(sm[msp-1]);
                sm[msp-1] = pd;
                pv_next = 1;
            end else if (pop_ok) begin
                exp_q.push_back(sm[msp-1]);
                msp--;
                pv_next = 1;
            end else if (push_ok) begin
                sm[msp] = pd;
                msp++;
            end
        end
        @(posedge clock);
        #1;
        mpv = pv_next;
        check_status("st");
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check("pop_valid", sif.pop_valid, mpv);
            if (mpv) begin
                if (exp_q.size() == 0) begin
                    check("sb_underrun", 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("pop_data", sif.pop_data, exp_d);
                end
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        sif.clear      = 1'b0;
        sif.push_valid = 1'b0;
        sif.push_data  = '0;
        sif.pop_req    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en  = 1;
        check_status("por");

        // Reset mid-stream: a pop accepted just before reset yields no pop_valid.
        cyc(1, 12'h005, 0, 0);
        cyc(1, 12'h006, 0, 0);
        cyc(0, 12'h000, 1, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_pop_valid", sif.pop_valid, 0);
        check_status("rst");
        sif.pop_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(0, 12'h000, 0, 0);

        // Push three, pop three back-to-back.
        cyc(1, 12'h111, 0, 0);
        cyc(1, 12'h222, 0, 0);
        cyc(1, 12'h333, 0, 0);
        repeat (3) cyc(0, 12'h000, 1, 0);
        cyc(0, 12'h000, 0, 0);

        // Fill to full, push+pop at full, overflow, then pop.
        for (int i = 0; i < 256; i++) cyc(1, 12'(i), 0, 0);
        cyc(1, 12'h0CD, 1, 0);
        cyc(1, 12'hFFF, 0, 0);
        cyc(0, 12'h000, 0, 0);
        cyc(0, 12'h000, 1, 0);
        cyc(0, 12'h000, 1, 0);
        cyc(0, 12'h000, 0, 0);

        // Underflow on empty, then clear.
        cyc(0, 12'h000, 0, 1);
        cyc(0, 12'h000, 1, 0);
        cyc(0, 12'h000, 0, 0);
        cyc(0, 12'h000, 0, 1);

        // Simultaneous push and pop with two entries.
        cyc(1, 12'hA00, 0, 0);
        cyc(1, 12'hB00, 0, 0);
        cyc(1, 12'hC00, 1, 0);
        cyc(0, 12'h000, 1, 0);
        cyc(0, 12'h000, 1, 0);
        cyc(0, 12'h000, 0, 0);

        // Push and pop together at empty: push alone proceeds, pop is rejected.
        cyc(0, 12'h000, 0, 1);
        cyc(1, 12'h777, 1, 0);
        cyc(1, 12'h888, 1, 0);
        cyc(0, 12'h000, 1, 0);
        cyc(1, 12'h999, 0, 1);
        cyc(0, 12'h000, 0, 0);

        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
